// File: rtl/noc_pkt_gen.sv
// noc_pkt_gen: turns one AXI-style descriptor into a train of head/body/tail NoC flits
module noc_pkt_gen #(
    parameter int         DATA_WIDTH     = 128,
    parameter int         ID_WIDTH       = 4,
    parameter int         VIRTUAL_CH_NUM = 16,
    parameter int         AXI_ADDR_WIDTH = 32,
    parameter int         FLIT_NUM_MAX   = 16,
    parameter int         GAP_CYCLES     = 2,
    parameter logic [2:0] TYPE_WRITE     = 3'b100,
    parameter logic [2:0] TYPE_RD_REQ    = 3'b010,
    parameter logic [3:0] HEAD_CODE_H    = 4'h5,
    parameter logic [3:0] HEAD_CODE_E    = 4'hA,
    parameter logic [3:0] TAIL_CODE_H    = 4'h0,
    parameter logic [3:0] TAIL_CODE_E    = 4'hF
) (
    input  logic                      noc_clk,
    input  logic                      noc_rst,
    input  logic                      cfg_start,
    input  logic                      cfg_rd,
    input  logic [7:0]                cfg_len,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [ID_WIDTH-1:0]       cfg_src_id,
    input  logic [ID_WIDTH-1:0]       cfg_dst_id,
    input  logic [DATA_WIDTH-1:0]     cfg_seed,
    input  logic                      nsu_busy,
    output logic [DATA_WIDTH:0]       noc2axi_data,
    output logic                      s_is_head,
    output logic                      s_is_tail,
    output logic                      gen_busy,
    output logic                      gen_done,
    output logic                      gen_err
);
    localparam int VW = VIRTUAL_CH_NUM;
    localparam int FW = $clog2(FLIT_NUM_MAX + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(FLIT_NUM_MAX * (DATA_WIDTH / 8));

    typedef enum logic [2:0] {IDLE, HEAD, BODY, TAIL, GAP, DONE} state_t;

    state_t                    state_q, state_d;
    logic                      rd_q, rd_d;
    logic [7:0]                len_q, len_d;
    logic [ID_WIDTH-1:0]       src_q, src_d;
    logic [ID_WIDTH-1:0]       dst_q, dst_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic [VW-1:0]             order_q, order_d;
    logic [VW-1:0]             num_q, num_d;
    logic [8:0]                left_q, left_d;
    logic [FW-1:0]             fcnt_q, fcnt_d;
    logic [GW-1:0]             gcnt_q, gcnt_d;
    logic [DATA_WIDTH:0]       out_q, out_d;
    logic                      head_q, head_d;
    logic                      tail_q, tail_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic [8:0]                npkt;
    logic                      bad;
    logic [2:0]                pkt_type;
    logic [AXI_ADDR_WIDTH-1:0] re_pack;
    logic [DATA_WIDTH-1:0]     head_flit;
    logic [DATA_WIDTH-1:0]     tail_flit;

    assign npkt      = 9'((int'(cfg_len) + FLIT_NUM_MAX) / FLIT_NUM_MAX);
    assign bad       = !cfg_rd && (int'(npkt) > VIRTUAL_CH_NUM);
    assign pkt_type  = rd_q ? TYPE_RD_REQ : TYPE_WRITE;
    assign re_pack   = AXI_ADDR_WIDTH'({VW'(1), len_q});
    assign head_flit = DATA_WIDTH'({HEAD_CODE_H, src_q, dst_q, pkt_type, order_q, len_q, addr_q, HEAD_CODE_E});
    assign tail_flit = DATA_WIDTH'({TAIL_CODE_H, src_q, dst_q, pkt_type, num_q, len_q, re_pack, TAIL_CODE_E});

    // next state and next flit; a busy NSU holds everything and emits a bubble
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        addr_d  = addr_q;
        data_d  = data_q;
        order_d = order_q;
        num_d   = num_q;
        left_d  = left_q;
        fcnt_d  = fcnt_q;
        gcnt_d  = gcnt_q;
        out_d   = '0;
        head_d  = 1'b0;
        tail_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = err_q;
        if (state_q == IDLE) begin
            if (cfg_start) begin
                rd_d    = cfg_rd;
                len_d   = cfg_len;
                src_d   = cfg_src_id;
                dst_d   = cfg_dst_id;
                addr_d  = cfg_addr;
                data_d  = cfg_seed;
                order_d = VW'(1);
                num_d   = cfg_rd ? VW'(1) : VW'(1) << (npkt - 9'd1);
                left_d  = {1'b0, cfg_len} + 9'd1;
                fcnt_d  = '0;
                gcnt_d  = '0;
                err_d   = err_q | bad;
                state_d = bad ? DONE : HEAD;
            end
        end else if (!nsu_busy) begin
            case (state_q)
                HEAD: begin
                    out_d   = {1'b1, head_flit};
                    head_d  = 1'b1;
                    state_d = rd_q ? TAIL : BODY;
                end
                BODY: begin
                    out_d   = {1'b1, data_q};
                    data_d  = data_q + 1'b1;
                    left_d  = left_q - 9'd1;
                    fcnt_d  = fcnt_q + 1'b1;
                    state_d = (fcnt_q == FW'(FLIT_NUM_MAX - 1) || left_q == 9'd1) ? TAIL : BODY;
                end
                TAIL: begin
                    out_d   = {1'b1, tail_flit};
                    tail_d  = 1'b1;
                    order_d = {order_q[VW-2:0], order_q[VW-1]};
                    addr_d  = addr_q + ADDR_STEP;
                    fcnt_d  = '0;
                    gcnt_d  = '0;
                    state_d = (rd_q || left_q == 9'd0) ? DONE : (GAP_CYCLES == 0 ? HEAD : GAP);
                end
                GAP: begin
                    gcnt_d  = gcnt_q + 1'b1;
                    state_d = (gcnt_q == GW'(GAP_CYCLES - 1)) ? HEAD : GAP;
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: ;
            endcase
        end
        busy_d = state_d != IDLE;
    end

    // state and output registers, synchronous reset aborts any transaction
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            order_q <= '0;
            num_q   <= '0;
            left_q  <= '0;
            fcnt_q  <= '0;
            gcnt_q  <= '0;
            out_q   <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            order_q <= order_d;
            num_q   <= num_d;
            left_q  <= left_d;
            fcnt_q  <= fcnt_d;
            gcnt_q  <= gcnt_d;
            out_q   <= out_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign noc2axi_data = out_q;
    assign s_is_head    = head_q;
    assign s_is_tail    = tail_q;
    assign gen_busy     = busy_q;
    assign gen_done     = done_q;
    assign gen_err      = err_q;
endmodule

// File: tb/tb_noc_pkt_gen.sv
// tb_noc_pkt_gen: random and directed descriptors checked against a packet-list model
module tb_noc_pkt_gen;
    localparam int F = 16;

    typedef struct {
        logic [128:0] f;
        logic         h;
        logic         t;
    } flit_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start0 = 1'b0, start8 = 1'b0;
    logic         cfg_rd = 1'b0;
    logic [7:0]   cfg_len = '0;
    logic [31:0]  cfg_addr = '0;
    logic [3:0]   cfg_src = '0, cfg_dst = '0;
    logic [127:0] cfg_seed = '0;
    logic         busy = 1'b0;
    logic [128:0] d0, d8, od;
    logic         h0, t0, b0, dn0, e0, h8, t8, b8, dn8, e8;
    logic         oh, ot, ob, odn, oe;
    int           sel = 0;
    int           n_chk = 0, n_fail = 0;
    bit           err8 = 0;
    logic [3:0]   ms, md;
    flit_t        exp_q[$];

    always #5 clk = ~clk;

    noc_pkt_gen dut (
        .noc_clk(clk), .noc_rst(rst), .cfg_start(start0), .cfg_rd(cfg_rd), .cfg_len(cfg_len),
        .cfg_addr(cfg_addr), .cfg_src_id(cfg_src), .cfg_dst_id(cfg_dst), .cfg_seed(cfg_seed),
        .nsu_busy(busy), .noc2axi_data(d0), .s_is_head(h0), .s_is_tail(t0), .gen_busy(b0),
        .gen_done(dn0), .gen_err(e0)
    );

    noc_pkt_gen #(.VIRTUAL_CH_NUM(8), .GAP_CYCLES(0)) dut8 (
        .noc_clk(clk), .noc_rst(rst), .cfg_start(start8), .cfg_rd(cfg_rd), .cfg_len(cfg_len),
        .cfg_addr(cfg_addr), .cfg_src_id(cfg_src), .cfg_dst_id(cfg_dst), .cfg_seed(cfg_seed),
        .nsu_busy(busy), .noc2axi_data(d8), .s_is_head(h8), .s_is_tail(t8), .gen_busy(b8),
        .gen_done(dn8), .gen_err(e8)
    );

    assign od  = sel != 0 ? d8 : d0;
    assign oh  = sel != 0 ? h8 : h0;
    assign ot  = sel != 0 ? t8 : t0;
    assign ob  = sel != 0 ? b8 : b0;
    assign odn = sel != 0 ? dn8 : dn0;
    assign oe  = sel != 0 ? e8 : e0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [128:0] mk(input logic [3:0] ch, input logic [3:0] ce, input logic [2:0] typ,
                                        input int oh_bit, input logic [7:0] len, input logic [31:0] w, input int vcn);
        logic [127:0] f;
        if (vcn == 16) f = 128'({ch, ms, md, typ, 16'(1) << oh_bit, len, w, ce});
        else           f = 128'({ch, ms, md, typ, 8'(1) << oh_bit, len, w, ce});
        return {1'b1, f};
    endfunction

    function automatic logic [31:0] repack(input logic [7:0] len, input int vcn);
        return vcn == 16 ? 32'({16'h0001, len}) : 32'({8'h01, len});
    endfunction

    task automatic build(input logic rd, input logic [7:0] len, input logic [31:0] addr, input logic [127:0] sd, input int vcn);
        int beats = int'(len) + 1;
        int npkt = (beats + F - 1) / F;
        logic [127:0] dat = sd;
        exp_q.delete();
        if (rd) begin
            exp_q.push_back('{f: mk(4'h5, 4'hA, 3'b010, 0, len, addr, vcn), h: 1'b1, t: 1'b0});
            exp_q.push_back('{f: mk(4'h0, 4'hF, 3'b010, 0, len, repack(len, vcn), vcn), h: 1'b0, t: 1'b1});
        end else if (npkt <= vcn) begin
            for (int k = 0; k < npkt; k++) begin
                int nb = (k < npkt - 1) ? F : beats - F * (npkt - 1);
                exp_q.push_back('{f: mk(4'h5, 4'hA, 3'b100, k, len, addr + 32'(k * F * 16), vcn), h: 1'b1, t: 1'b0});
                for (int j = 0; j < nb; j++) begin
                    exp_q.push_back('{f: {1'b1, dat}, h: 1'b0, t: 1'b0});
                    dat = dat + 1'b1;
                end
                exp_q.push_back('{f: mk(4'h0, 4'hF, 3'b100, npkt - 1, len, repack(len, vcn), vcn), h: 1'b0, t: 1'b1});
            end
        end
    endtask

    task automatic run(input int s, input logic rd, input logic [7:0] len, input logic [31:0] addr,
                       input logic [127:0] sd, input int bmode, input bit restart);
        int vcn = s != 0 ? 8 : 16;
        int gap = s != 0 ? 0 : 2;
        bit bad = !rd && ((int'(len) + F) / F) > vcn;
        int n = 0, last_tail = -1, done_k = -1, done_cnt = 0;
        bit pb = 0;
        ms = 4'($urandom);
        md = 4'($urandom);
        build(rd, len, addr, sd, vcn);
        sel = s;
        @(negedge clk);
        cfg_rd = rd; cfg_len = len; cfg_addr = addr; cfg_seed = sd; cfg_src = ms; cfg_dst = md; busy = 1'b0;
        if (s != 0) start8 = 1'b1; else start0 = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            start8 = 1'b0;
            if (k == 1) begin
                cfg_rd = 1'($urandom); cfg_len = 8'($urandom); cfg_addr = $urandom;
                cfg_seed = {$urandom, $urandom, $urandom, $urandom}; cfg_src = 4'($urandom); cfg_dst = 4'($urandom);
                chk("busy_after_start", ob, 1);
            end
            if (k == 2 && bmode == 0 && !bad) chk("head_latency", {oh, od[128]}, 2'b11);
            if (pb) chk("bubble", {od, oh, ot}, 0);
            if (od[128]) begin
                if (n < exp_q.size()) chk($sformatf("flit%0d", n), {ot, oh, od}, {exp_q[n].t, exp_q[n].h, exp_q[n].f});
                else chk("extra_flit", {ot, oh, od}, 0);
                if (oh && last_tail >= 0 && bmode == 0) chk("gap_len", k - last_tail - 1, gap);
                if (ot) last_tail = k;
                n++;
            end
            if (odn) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
                if (bmode == 0 && !bad) chk("done_latency", k - last_tail, 1);
            end
            if (restart && k == 10) begin
                if (s != 0) start8 = 1'b1; else start0 = 1'b1;
            end
            if (done_k > 0 && k >= done_k + 4) break;
            pb = bmode == 1 ? (k % 3 == 0) : bmode == 2 ? ($urandom_range(0, 3) == 0) : 1'b0;
            busy = pb;
        end
        busy = 1'b0;
        if (s != 0) err8 = err8 | bad;
        chk("flit_count", n, exp_q.size());
        chk("done_pulses", done_cnt, 1);
        chk("err_flag", oe, s != 0 ? err8 : 1'b0);
        chk("busy_end", ob, 0);
    endtask

    task automatic rst_mid();
        int tails = 0, bodies = 0;
        bit hit = 0;
        sel = 0;
        @(negedge clk);
        cfg_rd = 1'b0; cfg_len = 8'h29; cfg_addr = 32'h2000; cfg_seed = 128'h1; start0 = 1'b1;
        for (int k = 1; k <= 200 && !hit; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (od[128] && ot) begin
                tails++;
                bodies = 0;
            end else if (od[128] && !oh) bodies++;
            if (tails == 1 && bodies == 2) hit = 1;
        end
        chk("rst_point_reached", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        err8 = 0;
        chk("rst_abort", {od, oh, ot, odn, ob, oe}, 0);
        @(negedge clk);
        chk("rst_quiet", {od, oh, ot, odn, ob}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {d0, h0, t0, dn0, b0, e0, d8, h8, t8, dn8, b8, e8}, 0);
        rst = 1'b0;
        run(0, 1'b0, 8'h29, 32'h2000, 128'h1, 0, 0);
        run(0, 1'b1, 8'h0F, 32'h4000, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
        run(0, 1'b0, 8'h00, $urandom, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
        run(0, 1'b0, 8'h29, 32'h2000, 128'h1, 1, 0);
        run(0, 1'b0, 8'h29, 32'h2000, 128'h1, 0, 1);
        run(0, 1'b0, 8'h1F, 32'hFFFF_FF80, {128{1'b1}} - 128'd3, 0, 0);
        rst_mid();
        run(0, 1'b0, 8'h29, 32'h2000, 128'h1, 0, 0);
        for (int i = 0; i < 6; i++)
            run(0, 1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 90)), $urandom,
                {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2), 0);
        run(1, 1'b0, 8'h29, 32'h2000, 128'h1, 0, 0);
        run(1, 1'b0, 8'hFF, 32'h8000, 128'h5, 0, 0);
        run(1, 1'b0, 8'h7F, $urandom, {$urandom, $urandom, $urandom, $urandom}, 2, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/noc_pkt_gen.md
Name: noc_pkt_gen

Overview:
Parametrised NoC packet generator. It converts one AXI-style transaction descriptor into a train of NoC packets (head / body / tail flits) and drives them toward the NSU input.
It is the runtime-programmable successor of the fixed-pattern debug generator: it supports write and read-request packet types, arbitrary burst length, automatic splitting into multiple packets, per-packet address advance, backpressure bubbles and a configurable inter-packet gap.
It is used in NSU benches and on-board bring-up.

Parameters:
DATA_WIDTH, 128, flit payload width (valid bit added on top)
ID_WIDTH, 4, source/dest ID field width
VIRTUAL_CH_NUM, 16, width of one-hot PACK_ORDER/PACK_NUM fields; max packets per transaction
AXI_ADDR_WIDTH, 32, address field width
FLIT_NUM_MAX, 16, max body flits per packet
GAP_CYCLES, 2, idle cycles between packets (0 allowed)
TYPE_WRITE / TYPE_RD_REQ, 3'b100 / 3'b010, type codes
HEAD_CODE_H/E, 4'h5/4'hA; TAIL_CODE_H/E, 4'h0/4'hF, framing nibbles (4-bit codes)

Ports:
noc_clk  in  1  clock
noc_rst  in  1  reset; synchronous, active-high
cfg_start  in  1  one-cycle start pulse, sampled only in IDLE
cfg_rd  in  1  0 = write transaction, 1 = read request
cfg_len  in  8  AXI len; beats = cfg_len+1
cfg_addr  in  AXI_ADDR_WIDTH  start byte address
cfg_src_id, cfg_dst_id  in  ID_WIDTH  IDs
cfg_seed  in  DATA_WIDTH  first body data word
nsu_busy  in  1  backpressure from NSU
noc2axi_data  out  DATA_WIDTH+1  {valid, flit}
s_is_head, s_is_tail  out  1  flit markers
gen_busy  out  1  transaction in progress
gen_done  out  1  one-cycle pulse after final tail
gen_err  out  1  sticky: descriptor rejected

Behaviour:
- Reset:
  - All outputs are 0; the FSM goes to IDLE.
  - Reset asserted mid-transaction aborts immediately. The next cycle shows valid=0, and no partial tail is sent.
- Flit formats, MSB first after the valid bit; pad with zeros to DATA_WIDTH:
  - Head: HEAD_CODE_H, src, dst, type, pack_order, cfg_len, pkt_addr, HEAD_CODE_E.
  - Tail: TAIL_CODE_H, src, dst, type, pack_num, cfg_len, re_pack, TAIL_CODE_E.
  - re_pack = zero-extend of {first pack_order (VIRTUAL_CH_NUM bits), cfg_len} to AXI_ADDR_WIDTH.
  - Body: {1'b1, data}.
- Write packetisation:
  - npkt = ceil((cfg_len+1)/FLIT_NUM_MAX).
  - Packets 0..npkt-2 carry FLIT_NUM_MAX body flits; the last packet carries the remainder (1..FLIT_NUM_MAX).
  - pack_order starts at one-hot bit0 and rotates left once per packet.
  - pack_num = one-hot bit (npkt-1), constant for all packets.
  - pkt_addr = cfg_addr + k*FLIT_NUM_MAX*(DATA_WIDTH/8), modulo 2^AXI_ADDR_WIDTH.
  - Body data starts at cfg_seed and increments by 1 per emitted body flit, continuous across packets.
- Read request: one packet, head then tail, no body; pack_order = pack_num = one-hot bit0.
- Descriptor check: if npkt > VIRTUAL_CH_NUM, nothing is sent; gen_err is set (cleared only by reset); gen_done pulses.
- FSM states: IDLE -> (cfg_start) HEAD -> BODY (write) or TAIL (read) -> TAIL -> GAP (more packets) or DONE -> IDLE.
  - GAP lasts GAP_CYCLES cycles; with GAP_CYCLES=0 it is skipped.
  - DONE asserts gen_done for 1 cycle.
  - gen_busy is high in every state except IDLE.
- Timing:
  - Outputs are registered.
  - cfg_start at cycle t gives the head flit at t+2, or later if busy.
  - The descriptor is captured at start; cfg_* changes during a transaction have no effect.
  - cfg_start outside IDLE is ignored.
- Backpressure: if nsu_busy=1 at an edge, the next output is a bubble (all zero, head/tail=0) and the FSM, counters and data are frozen. nsu_busy=0 emits the next flit. A GAP count does not advance while busy.
- Each flit is emitted exactly once; consecutive valid flits need no gaps.

Test Plan:
- Write, cfg_len=8'h29, cfg_addr=32'h2000, seed=1, GAP_CYCLES=2, no busy -> 3 packets.
  - Bodies of 16, 16 and 10 flits.
  - Heads carry pack_order 0001/0002/0004 and addrs 2000/2100/2200.
  - All tails carry pack_num 0004 and re_pack 0x0000_0129.
  - Data runs 1..42.
  - Exactly 2 idle cycles between packets; gen_done 1 cycle after the last tail.
- Read request, cfg_len=8'h0F, addr 32'h4000 -> head (type 010, addr 4000), then tail on the next cycle; no body; gen_done pulses.
- Write, cfg_len=0 -> head, 1 body (seed), tail; pack_num = pack_order = 1.
- Write with nsu_busy toggling 1-of-3 cycles -> every busy-follow cycle is a bubble; flit sequence is identical to the no-busy run; no duplicates.
- VIRTUAL_CH_NUM=8, cfg_len=8'hFF (npkt 16) -> no valid flit; gen_err=1; gen_done pulses once.
- noc_rst for 1 cycle during the second body flit of packet 1 -> outputs 0 the next cycle, FSM IDLE; a new start then behaves as in the first scenario from the beginning.
- cfg_start pulsed mid-transaction -> ignored, and the packet count is unchanged.
